collision_result_reader: RTL

Drains collision results from the 7-word-per-record result RAM that `dCollideSpheres` outputs are written into. Each record is cx, cy, cz, normalx, normaly, normalz, depth. The block tracks how many complete records the writer has committed and issues synchronous reads against the RAM read port. It then streams the words out over a valid/ready interface, with word index and end-of-record markers, toward the host/JTAG readout path. A 2-entry output buffer with read-credit accounting sustains one word per cycle under continuous `out_ready`.

---
 rtl/collision_result_reader.sv | 103 ++++++++++
 1 files changed

// File: rtl/collision_result_reader.sv
`default_nettype none
// ============================================================================
// collision_result_reader: streams committed 7-word collision records from the
// result RAM ring onto a valid/ready port.                  Rev 1.0
// ============================================================================
module collision_result_reader #(
    parameter int RECORDS = 5,
    parameter int WORDS   = 7,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rec_written,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic [AW-1:0] pending,
    output logic          overflow,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(RECORDS * WORDS - 1);
    localparam logic [AW-1:0] MAX_PEND  = AW'(RECORDS);
    localparam logic [2:0]    LAST_IDX  = 3'(WORDS - 1);

    logic [2:0]  issue_idx;
    logic        inflight;
    logic [2:0]  inflight_idx;
    logic [31:0] buf_data [2];
    logic [2:0]  buf_idx  [2];
    logic        head;
    logic        tail;
    logic [1:0]  occ;

    logic        pop;
    logic        push;
    logic        dec;
    logic [2:0]  credit_used;

    // Credits count buffered words plus the read still in the RAM pipeline;
    // a word leaving this cycle frees its slot immediately.
    assign pop         = out_valid & out_ready;
    assign push        = inflight;
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en       = (pending != '0) && (credit_used < 3'd2);
    assign dec         = rd_en && (issue_idx == LAST_IDX);

    assign out_valid = (occ != 2'd0);
    assign out_data  = buf_data[head];
    assign out_idx   = buf_idx[head];
    assign out_last  = (buf_idx[head] == LAST_IDX);
    assign busy      = (pending != '0) || (occ != 2'd0) || inflight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr      <= '0;
            issue_idx    <= 3'd0;
            inflight     <= 1'b0;
            inflight_idx <= 3'd0;
            pending      <= '0;
            overflow     <= 1'b0;
            buf_data[0]  <= 32'd0;
            buf_data[1]  <= 32'd0;
            buf_idx[0]   <= 3'd0;
            buf_idx[1]   <= 3'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            occ          <= 2'd0;
        end else begin
            if (rd_en) begin
                rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
                issue_idx <= (issue_idx == LAST_IDX) ? 3'd0 : issue_idx + 3'd1;
            end
            inflight     <= rd_en;
            inflight_idx <= issue_idx;

            if (rec_written && !dec) begin
                if (pending == MAX_PEND)
                    overflow <= 1'b1;
                else
                    pending <= pending + AW'(1);
            end else if (!rec_written && dec) begin
                pending <= pending - AW'(1);
            end

            if (push) begin
                buf_data[tail] <= rd_data;
                buf_idx[tail]  <= inflight_idx;
                tail           <= ~tail;
            end
            if (pop)
                head <= ~head;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
`default_nettype wire
